// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command packet parser.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_CMD  = 2'd1,
    S_ARG  = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] CMD_FWD   = 8'h01;
  localparam logic [7:0] CMD_REV   = 8'h02;
  localparam logic [7:0] CMD_LEFT  = 8'h03;
  localparam logic [7:0] CMD_RIGHT = 8'h04;

  function automatic logic [7:0] calc_chk(input logic [7:0] i_cmd, input logic [7:0] i_arg);
    return i_cmd ^ i_arg;
  endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Saturating up-counter with synchronous clear; o_Expired is high while the count sits at LIMIT-1.
module cmd_timeout_ctr
  import uart_cmd_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  output logic o_Expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] MAX_COUNT = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (r_count != MAX_COUNT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Expired = (r_count == MAX_COUNT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into SYNC/CMD/ARG/CHK packets, validates them and tracks link liveness.
// Optional macro UART_CMD_FAILSAFE_EN forces o_Cmd/o_Arg to STOP/0 while the link is down.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned GAP_CLKS  = 2610,
  parameter int unsigned WDOG_CLKS = 1000000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cmd_DV,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Arg,
  output logic       o_Err,
  output logic       o_Link_Ok
);

  state_e     r_state, w_state_next;
  logic [7:0] r_cmd_sh, r_arg_sh;
  logic [7:0] r_cmd, r_arg;
  logic       r_cmd_dv, r_err, r_link_seen;

  logic w_gap_clear, w_gap_expired, w_timeout;
  logic w_chk_hit, w_pkt_ok, w_pkt_bad;
  logic w_wdog_expired, w_link_ok;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_gap_clear = i_Rx_DV || (r_state == S_SYNC);
  assign w_timeout   = (r_state != S_SYNC) && !i_Rx_DV && w_gap_expired;
  assign w_chk_hit   = (r_state == S_CHK) && i_Rx_DV;
  assign w_pkt_ok    = w_chk_hit && (i_Rx_Byte == calc_chk(r_cmd_sh, r_arg_sh));
  assign w_pkt_bad   = w_chk_hit && (i_Rx_Byte != calc_chk(r_cmd_sh, r_arg_sh));

  cmd_timeout_ctr #(
    .LIMIT (GAP_CLKS)
  ) u_gap_ctr (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Clear   (w_gap_clear),
    .o_Expired (w_gap_expired)
  );

  cmd_timeout_ctr #(
    .LIMIT (WDOG_CLKS)
  ) u_wdog_ctr (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Clear   (w_pkt_ok),
    .o_Expired (w_wdog_expired)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_SYNC;
    end else if (i_Rx_DV) begin
      case (r_state)
        S_SYNC:  w_state_next = (i_Rx_Byte == SYNC_BYTE) ? S_CMD : S_SYNC;
        S_CMD:   w_state_next = S_ARG;
        S_ARG:   w_state_next = S_CHK;
        S_CHK:   w_state_next = S_SYNC;
        default: w_state_next = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cmd_sh <= '0;
      r_arg_sh <= '0;
    end else if (w_timeout) begin
      r_cmd_sh <= '0;
      r_arg_sh <= '0;
    end else if (i_Rx_DV) begin
      if (r_state == S_CMD) r_cmd_sh <= i_Rx_Byte;
      if (r_state == S_ARG) r_arg_sh <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cmd_dv    <= 1'b0;
      r_err       <= 1'b0;
      r_cmd       <= '0;
      r_arg       <= '0;
      r_link_seen <= 1'b0;
    end else begin
      r_cmd_dv <= w_pkt_ok;
      r_err    <= w_pkt_bad || w_timeout;
      if (w_pkt_ok) begin
        r_cmd       <= r_cmd_sh;
        r_arg       <= r_arg_sh;
        r_link_seen <= 1'b1;
      end
    end
  end

  // The watchdog saturates, so once expired the link stays down until the next good packet.
  assign w_link_ok = r_link_seen && !w_wdog_expired;

  assign o_Cmd_DV  = r_cmd_dv;
  assign o_Err     = r_err;
  assign o_Link_Ok = w_link_ok;

`ifdef UART_CMD_FAILSAFE_EN
  assign o_Cmd = w_link_ok ? r_cmd : CMD_STOP;
  assign o_Arg = w_link_ok ? r_arg : 8'h00;
`else
  assign o_Cmd = r_cmd;
  assign o_Arg = r_arg;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected events, a monitor pops and checks.
module tb_uart_cmd_parser;

  localparam int unsigned GAP  = 2610;
  localparam int unsigned WDOG = 5000;
  localparam int unsigned SPC  = 870;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       cmd_dv, err, link_ok;
  logic [7:0] cmd, arg;

  uart_cmd_parser #(
    .SYNC_BYTE (8'hA5),
    .GAP_CLKS  (GAP),
    .WDOG_CLKS (WDOG)
  ) dut (
    .i_Clock   (clk),
    .i_Rst_n   (rst_n),
    .i_Rx_DV   (rx_dv),
    .i_Rx_Byte (rx_byte),
    .o_Cmd_DV  (cmd_dv),
    .o_Cmd     (cmd),
    .o_Arg     (arg),
    .o_Err     (err),
    .o_Link_Ok (link_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    bit         chk_vals;
    logic [7:0] cmd;
    logic [7:0] arg;
    int         exp_cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] last_arg = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n && (cmd_dv || err)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {30'd0, cmd_dv, err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("err_strobe", {31'd0, err}, {31'd0, e.is_err});
        check("dv_strobe", {31'd0, cmd_dv}, {31'd0, !e.is_err});
        if (e.exp_cyc >= 0) check("event_cycle", cyc, e.exp_cyc);
        if (!e.is_err || e.chk_vals) begin
          check("cmd_out", {24'd0, cmd}, {24'd0, e.cmd});
          check("arg_out", {24'd0, arg}, {24'd0, e.arg});
        end
      end
    end
  end

  // Called and returns just after a negedge; DUT samples the byte on the next posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] k, input int last_gap);
    exp_t e;
    send_byte(s, SPC);
    send_byte(c, SPC);
    send_byte(a, SPC);
    e.is_err   = (k != (c ^ a));
    e.chk_vals = 1'b1;
    if (!e.is_err) begin
      last_cmd = c;
      last_arg = a;
    end
    e.cmd     = last_cmd;
    e.arg     = last_arg;
    e.exp_cyc = cyc + 1;
    q.push_back(e);
    send_byte(k, last_gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_dv"}, {31'd0, cmd_dv}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_link"}, {31'd0, link_ok}, 32'd0);
    check({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
    check({tag, "_arg"}, {24'd0, arg}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish within bound");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Valid packet.
    send_pkt(8'hA5, 8'h01, 8'h40, 8'h41, SPC);
    check("link_up", {31'd0, link_ok}, 32'd1);

    // Bad checksum: expected 12, sent 13.
    send_pkt(8'hA5, 8'h02, 8'h10, 8'h13, SPC);

    // Inter-byte timeout after CMD byte; link may already be down, so values are not checked.
    send_byte(8'hA5, SPC);
    e.is_err = 1'b1; e.chk_vals = 1'b0; e.cmd = 8'h00; e.arg = 8'h00;
    e.exp_cyc = cyc + 1 + GAP;
    q.push_back(e);
    send_byte(8'h03, 1);
    repeat (GAP + 50) @(negedge clk);
    send_pkt(8'hA5, 8'h04, 8'h20, 8'h24, SPC);

    // Leading junk dropped; SYNC value accepted as data mid-packet.
    send_byte(8'h55, SPC);
    send_pkt(8'hA5, 8'hA5, 8'h00, 8'hA5, 1);

    // Watchdog: link stays up for WDOG-1 cycles after the accepting edge.
    n = 0;
    while (link_ok && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("link_high_cycles", n, WDOG - 1);
    check("link_down", {31'd0, link_ok}, 32'd0);
`ifdef UART_CMD_FAILSAFE_EN
    check("failsafe_cmd", {24'd0, cmd}, 32'h00);
    check("failsafe_arg", {24'd0, arg}, 32'h00);
`else
    check("held_cmd", {24'd0, cmd}, 32'hA5);
    check("held_arg", {24'd0, arg}, 32'h00);
`endif

    // Reset mid-packet.
    send_byte(8'hA5, SPC);
    send_byte(8'h01, 10);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    check_all_zero("inreset");
    rst_n = 1'b1;
    last_cmd = 8'h00;
    last_arg = 8'h00;
    @(negedge clk);
    send_pkt(8'hA5, 8'h01, 8'h7F, 8'h7E, SPC);
    check("link_up_after_reset", {31'd0, link_ok}, 32'd1);
    check("final_cmd", {24'd0, cmd}, 32'h01);
    check("final_arg", {24'd0, arg}, 32'h7F);

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
